// File: rtl/serializer_pkg.sv
// serializer_pkg: TMDS control words and slot-counter sizing shared by the serializer slice
package serializer_pkg;
   localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
   localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
   localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
   localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;
   function automatic int word_clks_w(input int dw, input int bpc);
      return (dw / bpc) > 1 ? $clog2(dw / bpc) : 1;
   endfunction
endpackage

// File: rtl/serializer_n_to_1_if.sv
// serializer_n_to_1_if: parallel-in handshake and serial-out bundle
// SERIALIZER_UNDERFLOW_CNT_EN adds the underflow_cnt signal
interface serializer_n_to_1_if #(
   parameter int DATA_WIDTH   = 10,
   parameter int CHANNELS     = 3,
   parameter int BITS_PER_CLK = 1
);
   logic                           in_valid;
   logic                           in_ready;
   logic [CHANNELS*DATA_WIDTH-1:0] in_data;
   logic [CHANNELS*BITS_PER_CLK-1:0] serial_out;
   logic                           word_start;
   logic                           underflow;
`ifdef SERIALIZER_UNDERFLOW_CNT_EN
   logic [15:0]                    underflow_cnt;
   modport master (output in_valid, in_data, input in_ready, serial_out, word_start, underflow, underflow_cnt);
   modport slave  (input in_valid, in_data, output in_ready, serial_out, word_start, underflow, underflow_cnt);
`else
   modport master (output in_valid, in_data, input in_ready, serial_out, word_start, underflow);
   modport slave  (input in_valid, in_data, output in_ready, serial_out, word_start, underflow);
`endif
endinterface

// File: rtl/serializer_lane.sv
// serializer_lane: one lane's shift register and registered transmit-end output
module serializer_lane #(
   parameter int                    DATA_WIDTH   = 10,
   parameter int                    BITS_PER_CLK = 1,
   parameter int                    MSB_FIRST    = 0,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD    = 10'b1101010100
) (
   input  logic                    serial_clk,
   input  logic                    reset_n,
   input  logic                    i_clr,
   input  logic                    i_load,
   input  logic [DATA_WIDTH-1:0]   i_word,
   output logic [BITS_PER_CLK-1:0] o_bits
);
   logic [DATA_WIDTH-1:0]   r_sr;
   logic [DATA_WIDTH-1:0]   w_sr_nxt;
   logic [BITS_PER_CLK-1:0] w_tx;
   logic [BITS_PER_CLK-1:0] r_bits;
   // output register takes the transmit end of the next shift value, so a load shows next cycle
   always_comb begin
      w_sr_nxt = i_clr ? IDLE_WORD : i_load ? i_word :
                 MSB_FIRST != 0 ? r_sr << BITS_PER_CLK : r_sr >> BITS_PER_CLK;
      w_tx = '0;
      for (int j = 0; j < BITS_PER_CLK; j++)
         w_tx[j] = MSB_FIRST != 0 ? w_sr_nxt[DATA_WIDTH-1-j] : w_sr_nxt[j];
   end
   always_ff @(posedge serial_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sr   <= IDLE_WORD;
         r_bits <= '0;
      end else begin
         r_sr   <= w_sr_nxt;
         r_bits <= w_tx;
      end
   end
   assign o_bits = r_bits;
endmodule

// File: rtl/serializer_n_to_1.sv
// serializer_n_to_1: lockstep N-lane parallel-to-serial converter with one-word holding register
// SERIALIZER_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow counter
module serializer_n_to_1
   import serializer_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 10,
   parameter int                    CHANNELS     = 3,
   parameter int                    BITS_PER_CLK = 1,
   parameter int                    MSB_FIRST    = 0,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD    = 10'b1101010100
) (
   input logic               serial_clk,
   input logic               reset_n,
   input logic               sync_clr,
   serializer_n_to_1_if.slave bus
);
   localparam int WORD_CLKS = DATA_WIDTH / BITS_PER_CLK;
   localparam int CW = word_clks_w(DATA_WIDTH, BITS_PER_CLK);
   localparam logic [CW-1:0] LAST = CW'(WORD_CLKS - 1);
   logic [CW-1:0]                    r_cnt;
   logic                             r_hold_full;
   logic [CHANNELS*DATA_WIDTH-1:0]   r_hold;
   logic                             r_en;
   logic                             r_first;
   logic                             r_word_start;
   logic                             r_underflow;
   logic                             w_load;
   logic                             w_ready;
   logic                             w_xfer;
   logic                             w_uf;
   logic [CHANNELS*DATA_WIDTH-1:0]   w_load_word;
   logic [CHANNELS*BITS_PER_CLK-1:0] w_serial;
   // r_en keeps in_ready low until the first edge after reset release
   always_comb begin
      w_load      = r_cnt == LAST;
      w_ready     = r_en && !sync_clr && (!r_hold_full || w_load);
      w_xfer      = bus.in_valid && w_ready;
      w_uf        = w_load && !sync_clr && !r_hold_full && !r_first;
      w_load_word = r_hold_full ? r_hold : {CHANNELS{IDLE_WORD}};
   end
   always_ff @(posedge serial_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt        <= LAST;
         r_hold_full  <= 1'b0;
         r_hold       <= '0;
         r_en         <= 1'b0;
         r_first      <= 1'b1;
         r_word_start <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         r_en         <= 1'b1;
         r_word_start <= w_load && !sync_clr;
         r_underflow  <= w_uf;
         if (sync_clr) begin
            r_cnt       <= LAST;
            r_hold_full <= 1'b0;
            r_first     <= 1'b1;
         end else begin
            r_cnt <= w_load ? '0 : r_cnt + 1'b1;
            if (w_load) r_first <= 1'b0;
            if (w_xfer) begin
               r_hold      <= bus.in_data;
               r_hold_full <= 1'b1;
            end else if (w_load) begin
               r_hold_full <= 1'b0;
            end
         end
      end
   end
   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      serializer_lane #(
         .DATA_WIDTH  (DATA_WIDTH),
         .BITS_PER_CLK(BITS_PER_CLK),
         .MSB_FIRST   (MSB_FIRST),
         .IDLE_WORD   (IDLE_WORD)
      ) u_lane (
         .serial_clk(serial_clk),
         .reset_n   (reset_n),
         .i_clr     (sync_clr),
         .i_load    (w_load),
         .i_word    (w_load_word[k*DATA_WIDTH +: DATA_WIDTH]),
         .o_bits    (w_serial[k*BITS_PER_CLK +: BITS_PER_CLK])
      );
   end
   assign bus.in_ready   = w_ready;
   assign bus.serial_out = w_serial;
   assign bus.word_start = r_word_start;
   assign bus.underflow  = r_underflow;
`ifdef SERIALIZER_UNDERFLOW_CNT_EN
   logic [15:0] r_ucnt;
   always_ff @(posedge serial_clk or negedge reset_n) begin
      if (!reset_n) r_ucnt <= '0;
      else if (sync_clr) r_ucnt <= '0;
      else if (w_uf && r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 1'b1;
   end
   assign bus.underflow_cnt = r_ucnt;
`endif
endmodule
